// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Target side of the core's data-memory load/store port. Takes one request
//   at a time over a valid/ready handshake and holds it for LATENCY wait
//   states. It then performs a word or byte-masked access on an internal RAM
//   and returns the result over a second valid/ready handshake. Doubles as a
//   slow-memory model for exercising LSU stalls.
//
// Parameters:
//   DEPTH       - RAM size in 32-bit words (power of two, >= 4)
//   LATENCY     - wait states from request accept to rsp_valid (1..15)
//   TOHOST_ADDR - byte address of the test-result register
//   PASS_VALUE  - value at TOHOST_ADDR that marks a test as passed
//
// Optional feature:
//   DMEM_TOHOST_EN - when defined, an error-free full-word store to
//   TOHOST_ADDR sets the sticky tohost_done flag. The same store sets
//   tohost_pass to (wdata == PASS_VALUE). When undefined, both flags are
//   tied low and no compare logic is built.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous reset, active low
//   req_valid   - request present
//   req_ready   - responder can accept a request
//   req_we      - 1 = store, 0 = load
//   req_addr    - byte address
//   req_wdata   - store data
//   req_be      - byte enables, bit i controls bits 8i+7:8i
//   rsp_valid   - response present
//   rsp_ready   - requester takes the response
//   rsp_rdata   - load data, 0 for stores and errors
//   rsp_err     - misaligned or out-of-range access
//   tohost_done - sticky, test-result register has been written
//   tohost_pass - last test-result write equalled PASS_VALUE
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int LATENCY     = 2,
  parameter int TOHOST_ADDR = 100,
  parameter int PASS_VALUE  = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        tohost_done,
  output logic        tohost_pass
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [3:0]     cnt;
  logic           we_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     be_q;
  logic           accept;
  logic           access;
  logic           addr_err;
  logic           ram_write;
  logic [AW-1:0]  word_idx;
  logic [31:0]    mem [DEPTH];

  // The error check and word index come from the latched request. Inputs
  // may change freely once the request has been accepted.
  assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(4 * DEPTH));
  assign word_idx  = addr_q[AW+1:2];
  assign ram_write = access && we_q && !addr_err;

  // State register. Reset forces IDLE, so an access pending in BUSY is
  // abandoned and a response in RESP disappears at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. 'access' marks the single cycle in
  // which the RAM is read or written and the response registers are loaded.
  // RESP always returns through IDLE, so a new request cannot be accepted
  // in the same cycle that a response is taken.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          access     = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, wait-state counter and response registers. Loading
  // LATENCY-1 makes the response appear on the LATENCY-th edge after accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rsp_err   <= addr_err;
        rsp_rdata <= (!we_q && !addr_err) ? mem[word_idx] : 32'd0;
      end
    end
  end

  // RAM storage is not reset. Writes are gated by the FSM, which sits in
  // IDLE while reset is held.
  always_ff @(posedge clk) begin
    if (ram_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

`ifdef DMEM_TOHOST_EN
  // Test-result register: only a clean full-word store to TOHOST_ADDR
  // counts. tohost_done stays set until reset. tohost_pass follows the
  // most recent such store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tohost_done <= 1'b0;
      tohost_pass <= 1'b0;
    end else if (ram_write && be_q == 4'hF && addr_q == 32'(TOHOST_ADDR)) begin
      tohost_done <= 1'b1;
      tohost_pass <= (wdata_q == 32'(PASS_VALUE));
    end
  end
`else
  assign tohost_done = 1'b0;
  assign tohost_pass = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. A plain word-array model of the
// memory predicts load data, error responses and the test-result flags.
// Directed cases and randomized transactions are checked against it. When
// DMEM_TOHOST_EN is undefined, the model expects both flags to stay low.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH       = 64;
  localparam int LAT         = 2;
  localparam int TOHOST_ADDR = 100;
  localparam int PASS_VALUE  = 25;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        tohost_done;
  logic        tohost_pass;

  int          checks;
  int          errors;

  logic [31:0] model_mem [DEPTH];
  logic        exp_done;
  logic        exp_pass;
  logic [31:0] last_rdata;

  dmem_responder #(
    .DEPTH      (DEPTH),
    .LATENCY    (LAT),
    .TOHOST_ADDR(TOHOST_ADDR),
    .PASS_VALUE (PASS_VALUE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .tohost_done(tohost_done),
    .tohost_pass(tohost_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one access: error rules, byte-masked store into
  // the word array, full-word load and the test-result flags.
  task automatic modelAccess(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output logic [31:0] exp_rdata, output logic exp_err);
    int idx;
    exp_err   = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    exp_rdata = 32'd0;
    idx       = int'(addr / 4);
    if (!exp_err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
`ifdef DMEM_TOHOST_EN
        if (addr == TOHOST_ADDR && be == 4'hF) begin
          exp_done = 1'b1;
          exp_pass = (wdata == PASS_VALUE);
        end
`endif
      end else begin
        exp_rdata = model_mem[idx];
      end
    end
  endtask

  // Present a request and wait for it to be taken. Returns 1 time unit
  // after the accepting edge with req_valid dropped.
  task automatic startReq(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    int waited;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    waited    = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready) checkOutput("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Count edges from the accepting edge until rsp_valid is seen.
  task automatic waitResp();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rsp_valid && n < 40);
    checkOutput("latency", 32'(n), 32'(LAT));
  endtask

  task automatic checkResp(input logic [31:0] exp_rdata, input logic exp_err);
    checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    checkOutput("req_ready_busy", {31'd0, req_ready}, 32'd0);
    checkOutput("tohost_done", {31'd0, tohost_done}, {31'd0, exp_done});
    checkOutput("tohost_pass", {31'd0, tohost_pass}, {31'd0, exp_pass});
    last_rdata = rsp_rdata;
  endtask

  // Hold off the response for 'stall' cycles, checking that it stays
  // stable, then take it.
  task automatic endResp(input int stall, input logic [31:0] exp_rdata,
                         input logic exp_err);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      checkOutput("stall_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("stall_rdata", rsp_rdata, exp_rdata);
      checkOutput("stall_err", {31'd0, rsp_err}, {31'd0, exp_err});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_taken", {31'd0, rsp_valid}, 32'd0);
    checkOutput("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // One complete transaction against the model.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input int stall);
    logic [31:0] er;
    logic        ee;
    startReq(we, addr, wdata, be);
    modelAccess(we, addr, wdata, be, er, ee);
    waitResp();
    checkResp(er, ee);
    endResp(stall, er, ee);
  endtask

  task automatic resetModelFlags();
    exp_done = 1'b0;
    exp_pass = 1'b0;
  endtask

  initial begin
    logic [31:0] er;
    logic        ee;
    logic [31:0] addr;
    logic [31:0] word63;

    checks     = 0;
    errors     = 0;
    last_rdata = 32'd0;
    resetModelFlags();
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_be     = 4'd0;
    rsp_ready  = 1'b0;

    // Reset state, during and just after reset.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("rst_done", {31'd0, tohost_done}, 32'd0);
    checkOutput("rst_pass", {31'd0, tohost_pass}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("post_rst_done", {31'd0, tohost_done}, 32'd0);

    // Fill every word so that later loads have known contents.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'(i * 4), $urandom, 4'hF, 0);
    end

    // Directed store/load and byte-mask merge.
    applyStimulus(1'b1, 32'h10, 32'h1234_5678, 4'hF, 0);
    applyStimulus(1'b0, 32'h10, 32'd0, 4'h0, 0);
    checkOutput("word_readback", last_rdata, 32'h1234_5678);
    applyStimulus(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 0);
    applyStimulus(1'b0, 32'h10, 32'd0, 4'hF, 0);
    checkOutput("byte_mask", last_rdata, 32'h12BB_56DD);

    // Empty byte mask is a legal no-op.
    applyStimulus(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0);
    applyStimulus(1'b0, 32'h10, 32'd0, 4'hF, 0);
    checkOutput("be_zero", last_rdata, 32'h12BB_56DD);

    // Error cases: misaligned load, store just past the end.
    applyStimulus(1'b0, 32'h13, 32'd0, 4'hF, 0);
    applyStimulus(1'b0, 32'hFC, 32'd0, 4'hF, 0);
    word63 = last_rdata;
    applyStimulus(1'b1, 32'(4 * DEPTH), 32'hDEAD_BEEF, 4'hF, 0);
    applyStimulus(1'b0, 32'hFC, 32'd0, 4'hF, 0);
    checkOutput("oob_no_write", last_rdata, word63);

    // Backpressure: a new request waits while the response is held.
    startReq(1'b0, 32'h10, 32'd0, 4'hF);
    modelAccess(1'b0, 32'h10, 32'd0, 4'hF, er, ee);
    waitResp();
    checkResp(er, ee);
    req_we    = 1'b0;
    req_addr  = 32'h14;
    req_be    = 4'hF;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_rdata", rsp_rdata, er);
      checkOutput("bp_err", {31'd0, rsp_err}, {31'd0, ee});
      checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("bp_released", {31'd0, rsp_valid}, 32'd0);
    checkOutput("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("bp_accepted", {31'd0, req_ready}, 32'd0);
    modelAccess(1'b0, 32'h14, 32'd0, 4'hF, er, ee);
    waitResp();
    checkResp(er, ee);
    endResp(0, er, ee);

    // Test-result register sequence.
    applyStimulus(1'b1, 32'd96, 32'd96, 4'hF, 0);
    applyStimulus(1'b1, 32'(TOHOST_ADDR), 32'(PASS_VALUE), 4'hF, 0);
    applyStimulus(1'b1, 32'(TOHOST_ADDR), 32'd7, 4'hF, 1);

    // Reset while BUSY: no response, no write, flags cleared.
    startReq(1'b1, 32'(TOHOST_ADDR), 32'(PASS_VALUE), 4'hF);
    reset = 1'b0;
    #1;
    resetModelFlags();
    checkOutput("abort_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("abort_done", {31'd0, tohost_done}, 32'd0);
    checkOutput("abort_pass", {31'd0, tohost_pass}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    applyStimulus(1'b0, 32'(TOHOST_ADDR), 32'd0, 4'hF, 0);

    // Reset while in RESP drops the response immediately.
    startReq(1'b0, 32'h20, 32'd0, 4'hF);
    modelAccess(1'b0, 32'h20, 32'd0, 4'hF, er, ee);
    waitResp();
    checkResp(er, ee);
    reset = 1'b0;
    #1;
    resetModelFlags();
    checkOutput("resp_rst_drop", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic with assorted address classes and stalls.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0: addr = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        1: addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 1023));
        2: addr = 32'(TOHOST_ADDR);
        default: addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      applyStimulus(1'($urandom_range(0, 1)), addr,
                    ($urandom_range(0, 3) == 0) ? 32'(PASS_VALUE) : $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
